sonar_tof_capture: RTL and testbench



---
 rtl/sonar_pkg.sv | 31 +++
 rtl/sonar_tof_capture_if.sv | 19 +
 rtl/sonar_echo_fifo.sv | 57 +++++
 rtl/sonar_tof_capture.sv | 227 ++++++++++++++++++++++
 tb/tb_sonar_tof_capture.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar time-of-flight capture stage:
// register map, state encoding and CONTROL/STATUS bit positions.
package sonar_pkg;

  localparam logic [3:0] ADDR_CONTROL    = 4'd0;
  localparam logic [3:0] ADDR_STATUS     = 4'd1;
  localparam logic [3:0] ADDR_BLANK      = 4'd2;
  localparam logic [3:0] ADDR_WINDOW     = 4'd3;
  localparam logic [3:0] ADDR_THR_HI_L   = 4'd4;
  localparam logic [3:0] ADDR_THR_HI_H   = 4'd5;
  localparam logic [3:0] ADDR_THR_LO_L   = 4'd6;
  localparam logic [3:0] ADDR_THR_LO_H   = 4'd7;
  localparam logic [3:0] ADDR_CH_SEL     = 4'd8;
  localparam logic [3:0] ADDR_ECHO_COUNT = 4'd9;
  localparam logic [3:0] ADDR_ECHO_POP   = 4'd10;
  localparam logic [3:0] ADDR_TIMER      = 4'd11;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int STAT_IRQ     = 2;
  localparam int STAT_OVF_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_LISTEN = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/sonar_tof_capture_if.sv
// Register bus bundle between the host side and the capture stage.
interface sonar_tof_capture_if;
  logic        wb_valid_i;
  logic [3:0]  wbs_adr_i;
  logic [15:0] wbs_dat_i;
  logic        wbs_strb_i;
  logic        wbs_ack_o;
  logic [15:0] wbs_dat_o;

  modport master (
    output wb_valid_i, wbs_adr_i, wbs_dat_i, wbs_strb_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wb_valid_i, wbs_adr_i, wbs_dat_i, wbs_strb_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/sonar_echo_fifo.sv
// Per-channel echo timestamp FIFO. DEPTH must be a power of two; pointers
// wrap by masking. A push while full is accepted only with a simultaneous pop.
module sonar_echo_fifo #(
  parameter int DEPTH = 4,
  parameter int TW    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [TW-1:0]            din,
  output logic [TW-1:0]            dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_MASK = AW'(DEPTH - 1);

  logic [TW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          push_ok, pop_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  // Storage, pointers and occupancy; a clear empties the FIFO without touching data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr + AW'(1)) & PTR_MASK;
      end
      if (pop_ok) rd_ptr <= (rd_ptr + AW'(1)) & PTR_MASK;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/sonar_tof_capture.sv
// Multi-channel sonar time-of-flight capture: ping-synchronous listen window
// with blanking, per-channel threshold detector and echo timestamp FIFOs,
// 16-bit register bus and window-done interrupt.
// Optional build macro SONAR_TOF_HYST_EN: adds THR_LO and rearms on env < THR_LO.
module sonar_tof_capture
  import sonar_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DW         = 32,
  parameter int TW         = 16,
  parameter int ECHO_DEPTH = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  sonar_tof_capture_if.slave     bus,
  input  logic                   env_valid_i,
  input  logic [NUM_CH*DW-1:0]   env_i,
  input  logic                   trig_i,
  output logic [NUM_CH-1:0]      echo_o,
  output logic                   irq_o
);
  localparam int CW = $clog2(ECHO_DEPTH) + 1;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, blank_q, window_q, win_last;
  logic [DW-1:0]     thr_hi_q;
`ifdef SONAR_TOF_HYST_EN
  logic [DW-1:0]     thr_lo_q;
`endif
  logic [2:0]        ch_sel_q;
  logic              irq_en_q, irq_q, ack_q;
  logic [15:0]       dat_q, rdata;
  logic [NUM_CH-1:0] armed_q, echo_q, ovf_q;
  logic [NUM_CH-1:0] hit, rearm, push, pop, full, empty;
  logic [TW-1:0]     fifo_dout [NUM_CH];
  logic [CW-1:0]     fifo_cnt  [NUM_CH];
  logic              acc, wr_acc, rd_acc, start_cmd, abort_cmd, go;
  logic              clear, sample_en, done_evt, last_sample, blanked;

  assign acc       = bus.wb_valid_i && !ack_q;
  assign wr_acc    = acc && bus.wbs_strb_i;
  assign rd_acc    = acc && !bus.wbs_strb_i;
  assign start_cmd = wr_acc && (bus.wbs_adr_i == ADDR_CONTROL) && bus.wbs_dat_i[CTRL_START];
  assign abort_cmd = wr_acc && (bus.wbs_adr_i == ADDR_CONTROL) && bus.wbs_dat_i[CTRL_ABORT];
  assign go        = start_cmd || trig_i;

  // A zero WINDOW is treated as a single-sample window
  assign win_last    = (window_q == '0) ? '0 : window_q - TW'(1);
  assign last_sample = (timer_q == win_last);
  assign blanked     = (timer_q < blank_q);

  // Ping state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next state plus the clear/sample/done strobes; abort beats any start
  always_comb begin
    state_d   = state_q;
    clear     = 1'b0;
    sample_en = 1'b0;
    done_evt  = 1'b0;
    if (abort_cmd) begin
      state_d = ST_IDLE;
      clear   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (go) begin
            state_d = ST_ARMED;
            clear   = 1'b1;
          end
        end
        ST_ARMED, ST_LISTEN: begin
          if (env_valid_i) begin
            sample_en = 1'b1;
            if (last_sample) begin
              state_d  = ST_DONE;
              done_evt = 1'b1;
            end else begin
              state_d = ST_LISTEN;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sample timer: t of the current sample, stops once the window is consumed
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)     timer_q <= '0;
    else if (clear)     timer_q <= '0;
    else if (sample_en) timer_q <= timer_q + TW'(1);
  end

  // Per-channel detection, rearm and FIFO push/pop decisions
  always_comb begin
    hit   = '0;
    rearm = '0;
    pop   = '0;
    push  = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      hit[ch] = sample_en && !blanked && armed_q[ch] && (env_i[ch*DW +: DW] > thr_hi_q);
`ifdef SONAR_TOF_HYST_EN
      rearm[ch] = sample_en && !armed_q[ch] && (env_i[ch*DW +: DW] < thr_lo_q);
`else
      rearm[ch] = sample_en && !armed_q[ch] && (env_i[ch*DW +: DW] <= thr_hi_q);
`endif
      pop[ch]  = rd_acc && (bus.wbs_adr_i == ADDR_ECHO_POP) && (ch_sel_q == 3'(ch)) && !empty[ch];
      push[ch] = hit[ch] && (!full[ch] || pop[ch]);
    end
  end

  // Detector arm state, echo flags and sticky overflow
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      armed_q <= '0;
      echo_q  <= '0;
      ovf_q   <= '0;
    end else if (clear) begin
      armed_q <= '1;
      echo_q  <= '0;
      ovf_q   <= '0;
    end else begin
      armed_q <= (armed_q & ~hit) | rearm;
      echo_q  <= echo_q | hit;
      ovf_q   <= ovf_q | (hit & full & ~pop);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    sonar_echo_fifo #(.DEPTH(ECHO_DEPTH), .TW(TW)) u_fifo (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_ni),
      .clr   (clear),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   (timer_q),
      .dout  (fifo_dout[g]),
      .count (fifo_cnt[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  // Bus acknowledge, registered read data and configuration writes
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_en_q <= 1'b0;
      blank_q  <= '0;
      window_q <= '0;
      thr_hi_q <= '0;
`ifdef SONAR_TOF_HYST_EN
      thr_lo_q <= '0;
`endif
      ch_sel_q <= '0;
    end else begin
      ack_q <= acc;
      dat_q <= rd_acc ? rdata : '0;
      if (wr_acc) begin
        case (bus.wbs_adr_i)
          ADDR_CONTROL:  irq_en_q           <= bus.wbs_dat_i[CTRL_IRQ_EN];
          ADDR_BLANK:    blank_q            <= bus.wbs_dat_i[TW-1:0];
          ADDR_WINDOW:   window_q           <= bus.wbs_dat_i[TW-1:0];
          ADDR_THR_HI_L: thr_hi_q[15:0]     <= bus.wbs_dat_i;
          ADDR_THR_HI_H: thr_hi_q[DW-1:16]  <= bus.wbs_dat_i[DW-17:0];
`ifdef SONAR_TOF_HYST_EN
          ADDR_THR_LO_L: thr_lo_q[15:0]     <= bus.wbs_dat_i;
          ADDR_THR_LO_H: thr_lo_q[DW-1:16]  <= bus.wbs_dat_i[DW-17:0];
`endif
          ADDR_CH_SEL:   ch_sel_q           <= bus.wbs_dat_i[2:0];
          default: ;
        endcase
      end
    end
  end

  // Window-done interrupt: set on entering DONE, cleared by start/abort or any STATUS write
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                  irq_q <= 1'b0;
    else if (clear)                  irq_q <= 1'b0;
    else if (done_evt && irq_en_q)   irq_q <= 1'b1;
    else if (wr_acc && (bus.wbs_adr_i == ADDR_STATUS)) irq_q <= 1'b0;
  end

  // Read data mux for the addressed register
  always_comb begin
    rdata = '0;
    case (bus.wbs_adr_i)
      ADDR_CONTROL: rdata[CTRL_IRQ_EN] = irq_en_q;
      ADDR_STATUS: begin
        rdata[1:0]                     = state_q;
        rdata[STAT_IRQ]                = irq_q;
        rdata[STAT_OVF_LSB +: NUM_CH]  = ovf_q;
      end
      ADDR_BLANK:    rdata = 16'(blank_q);
      ADDR_WINDOW:   rdata = 16'(window_q);
      ADDR_THR_HI_L: rdata = thr_hi_q[15:0];
      ADDR_THR_HI_H: rdata = 16'(thr_hi_q[DW-1:16]);
`ifdef SONAR_TOF_HYST_EN
      ADDR_THR_LO_L: rdata = thr_lo_q[15:0];
      ADDR_THR_LO_H: rdata = 16'(thr_lo_q[DW-1:16]);
`endif
      ADDR_CH_SEL:   rdata = 16'(ch_sel_q);
      ADDR_ECHO_COUNT: begin
        for (int ch = 0; ch < NUM_CH; ch++)
          if (ch_sel_q == 3'(ch)) rdata = 16'(fifo_cnt[ch]);
      end
      ADDR_ECHO_POP: begin
        for (int ch = 0; ch < NUM_CH; ch++)
          if ((ch_sel_q == 3'(ch)) && !empty[ch]) rdata = 16'(fifo_dout[ch]);
      end
      ADDR_TIMER:    rdata = 16'(timer_q);
      default:       rdata = '0;
    endcase
  end

  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = dat_q;
  assign echo_o        = echo_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_sonar_tof_capture.sv
// Directed testbench for sonar_tof_capture. Bus reads push their expected data
// into a scoreboard queue; a monitor compares whenever the DUT acknowledges.
module tb_sonar_tof_capture;
  import sonar_pkg::*;

  localparam int NUM_CH     = 4;
  localparam int DW         = 32;
  localparam int TW         = 16;
  localparam int ECHO_DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  env_valid = 1'b0;
  logic                  trig = 1'b0;
  logic [NUM_CH*DW-1:0]  env = '0;
  logic [NUM_CH-1:0]     echo;
  logic                  irq;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_val_q[$];
  string       exp_name_q[$];
  logic [15:0] mon_exp;
  string       mon_name;

  sonar_tof_capture_if bus_if();

  sonar_tof_capture #(
    .NUM_CH(NUM_CH), .DW(DW), .TW(TW), .ECHO_DEPTH(ECHO_DEPTH)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .bus         (bus_if),
    .env_valid_i (env_valid),
    .env_i       (env),
    .trig_i      (trig),
    .echo_o      (echo),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every acknowledge consumes one expected read value
  always @(negedge clk) begin
    if (rst_n && bus_if.wbs_ack_o) begin
      if (exp_val_q.size() == 0) begin
        checkOutput("unexpected_ack", 32'(bus_if.wbs_dat_o), 32'hDEAD_BEEF);
      end else begin
        mon_exp  = exp_val_q.pop_front();
        mon_name = exp_name_q.pop_front();
        checkOutput(mon_name, 32'(bus_if.wbs_dat_o), 32'(mon_exp));
      end
    end
  end

  function automatic logic [NUM_CH*DW-1:0] env1(input int ch, input int v);
    logic [NUM_CH*DW-1:0] r;
    r = '0;
    r[ch*DW +: DW] = DW'(v);
    return r;
  endfunction

  task automatic busAccess(input bit we, input logic [3:0] a, input logic [15:0] d,
                           input logic [15:0] e, input string nm);
    int n;
    n = 0;
    exp_val_q.push_back(we ? 16'h0000 : e);
    exp_name_q.push_back(nm);
    bus_if.wb_valid_i = 1'b1;
    bus_if.wbs_adr_i  = a;
    bus_if.wbs_dat_i  = d;
    bus_if.wbs_strb_i = we;
    tick();
    while (!bus_if.wbs_ack_o && n < 8) begin
      tick();
      n++;
    end
    if (!bus_if.wbs_ack_o) checkOutput({nm, "_ack_timeout"}, 32'(bus_if.wbs_ack_o), 32'd1);
    bus_if.wb_valid_i = 1'b0;
    bus_if.wbs_strb_i = 1'b0;
    tick();
  endtask

  task automatic writeReg(input logic [3:0] a, input logic [15:0] d);
    busAccess(1'b1, a, d, 16'h0, "write_data_zero");
  endtask

  task automatic readReg(input logic [3:0] a, input logic [15:0] e, input string nm);
    busAccess(1'b0, a, 16'h0, e, nm);
  endtask

  // One sample strobe followed by an idle cycle
  task automatic applyStimulus(input logic [NUM_CH*DW-1:0] v);
    env       = v;
    env_valid = 1'b1;
    tick();
    env_valid = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus_if.wb_valid_i = 1'b0;
    bus_if.wbs_adr_i  = '0;
    bus_if.wbs_dat_i  = '0;
    bus_if.wbs_strb_i = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_echo", 32'(echo), 32'd0);
    checkOutput("rst_irq", 32'(irq), 32'd0);
    checkOutput("rst_ack", 32'(bus_if.wbs_ack_o), 32'd0);
    checkOutput("rst_dat", 32'(bus_if.wbs_dat_o), 32'd0);
    rst_n = 1'b1;
    tick();
    readReg(ADDR_STATUS, 16'h0000, "rst_status");
    readReg(ADDR_TIMER, 16'h0000, "rst_timer");

    // Ping 1: blanking hides the t=5 peak, t=20 is the only echo on ch1
    writeReg(ADDR_BLANK, 16'd10);
    writeReg(ADDR_WINDOW, 16'd100);
    writeReg(ADDR_THR_HI_L, 16'd1000);
    writeReg(ADDR_THR_HI_H, 16'd0);
    writeReg(ADDR_THR_LO_L, 16'd500);
    writeReg(ADDR_THR_LO_H, 16'd0);
    writeReg(ADDR_CH_SEL, 16'd1);
    readReg(ADDR_THR_HI_L, 16'd1000, "thr_hi_rd");
`ifdef SONAR_TOF_HYST_EN
    readReg(ADDR_THR_LO_L, 16'd500, "thr_lo_rd");
`else
    readReg(ADDR_THR_LO_L, 16'd0, "thr_lo_absent");
`endif
    writeReg(ADDR_CONTROL, 16'h0001);
    readReg(ADDR_STATUS, 16'h0001, "p1_armed");
    for (int t = 0; t < 100; t++)
      applyStimulus(env1(1, (t == 5 || t == 20) ? 2000 : 500));
    readReg(ADDR_STATUS, 16'h0003, "p1_done");
    checkOutput("p1_echo", 32'(echo), 32'h2);
    readReg(ADDR_ECHO_COUNT, 16'd1, "p1_count");
    readReg(ADDR_ECHO_POP, 16'd20, "p1_pop");
    readReg(ADDR_ECHO_POP, 16'd0, "p1_pop_empty");
    readReg(ADDR_ECHO_COUNT, 16'd0, "p1_count_after");
    readReg(ADDR_TIMER, 16'd100, "p1_timer_stop");

    // Ping 2: ch0 square wave, fifth echo overflows
    writeReg(ADDR_BLANK, 16'd0);
    writeReg(ADDR_CH_SEL, 16'd0);
    writeReg(ADDR_CONTROL, 16'h0001);
    for (int t = 0; t < 100; t++)
      applyStimulus(env1(0, ((t / 10) % 2 == 0) ? 2000 : 100));
    readReg(ADDR_STATUS, 16'h0103, "p2_status_ovf");
    checkOutput("p2_echo", 32'(echo), 32'h1);
    readReg(ADDR_ECHO_COUNT, 16'd4, "p2_count");
    readReg(ADDR_ECHO_POP, 16'd0, "p2_pop0");
    readReg(ADDR_ECHO_POP, 16'd20, "p2_pop1");
    readReg(ADDR_ECHO_POP, 16'd40, "p2_pop2");
    readReg(ADDR_ECHO_POP, 16'd60, "p2_pop3");
    readReg(ADDR_ECHO_COUNT, 16'd0, "p2_count_after");

    // Ping 3: sustained envelope with a dip to 800 at t=30
    writeReg(ADDR_WINDOW, 16'd40);
    writeReg(ADDR_CONTROL, 16'h0001);
    for (int t = 0; t < 40; t++)
      applyStimulus(env1(0, (t == 30) ? 800 : 2000));
`ifdef SONAR_TOF_HYST_EN
    readReg(ADDR_ECHO_COUNT, 16'd1, "p3_count_hyst");
    readReg(ADDR_ECHO_POP, 16'd0, "p3_pop0_hyst");
    readReg(ADDR_ECHO_POP, 16'd0, "p3_pop_empty_hyst");
`else
    readReg(ADDR_ECHO_COUNT, 16'd2, "p3_count");
    readReg(ADDR_ECHO_POP, 16'd0, "p3_pop0");
    readReg(ADDR_ECHO_POP, 16'd31, "p3_pop1");
`endif

    // Ping 4: interrupt on the 8th strobe, start ignored while listening
    writeReg(ADDR_WINDOW, 16'd8);
    writeReg(ADDR_CONTROL, 16'h0005);
    for (int t = 0; t < 7; t++) applyStimulus('0);
    checkOutput("p4_irq_before", 32'(irq), 32'd0);
    readReg(ADDR_STATUS, 16'h0002, "p4_listen");
    writeReg(ADDR_CONTROL, 16'h0005);
    readReg(ADDR_TIMER, 16'd7, "p4_start_ignored");
    applyStimulus('0);
    checkOutput("p4_irq_set", 32'(irq), 32'd1);
    readReg(ADDR_STATUS, 16'h0007, "p4_status_irq");
    writeReg(ADDR_STATUS, 16'h0000);
    checkOutput("p4_irq_cleared", 32'(irq), 32'd0);
    readReg(ADDR_STATUS, 16'h0003, "p4_status_clr");

    // Ping 5: ch2 pop coincides with a detection into a full FIFO
    writeReg(ADDR_WINDOW, 16'd100);
    writeReg(ADDR_CH_SEL, 16'd2);
    writeReg(ADDR_CONTROL, 16'h0001);
    for (int t = 0; t < 8; t++)
      applyStimulus(env1(2, (t % 2 == 0) ? 2000 : 100));
    readReg(ADDR_ECHO_COUNT, 16'd4, "p5_count_full");
    exp_val_q.push_back(16'd0);
    exp_name_q.push_back("p5_pop_same_cycle");
    bus_if.wb_valid_i = 1'b1;
    bus_if.wbs_adr_i  = ADDR_ECHO_POP;
    bus_if.wbs_strb_i = 1'b0;
    env               = env1(2, 2000);
    env_valid         = 1'b1;
    tick();
    env_valid         = 1'b0;
    bus_if.wb_valid_i = 1'b0;
    tick();
    readReg(ADDR_ECHO_COUNT, 16'd4, "p5_count_kept");
    readReg(ADDR_STATUS, 16'h0002, "p5_no_ovf");
    readReg(ADDR_ECHO_POP, 16'd2, "p5_pop_a");
    readReg(ADDR_ECHO_POP, 16'd4, "p5_pop_b");
    readReg(ADDR_ECHO_POP, 16'd6, "p5_pop_c");
    readReg(ADDR_ECHO_POP, 16'd8, "p5_pop_d");
    applyStimulus(env1(2, 100));
    applyStimulus(env1(2, 2000));
    readReg(ADDR_ECHO_COUNT, 16'd1, "p5_count_refill");
    checkOutput("p5_echo", 32'(echo), 32'h4);

    // Abort+start write together with trig during LISTEN
    exp_val_q.push_back(16'd0);
    exp_name_q.push_back("abort_write_data");
    bus_if.wb_valid_i = 1'b1;
    bus_if.wbs_adr_i  = ADDR_CONTROL;
    bus_if.wbs_dat_i  = 16'h0003;
    bus_if.wbs_strb_i = 1'b1;
    trig              = 1'b1;
    tick();
    trig              = 1'b0;
    bus_if.wb_valid_i = 1'b0;
    bus_if.wbs_strb_i = 1'b0;
    tick();
    readReg(ADDR_STATUS, 16'h0000, "abort_idle");
    readReg(ADDR_ECHO_COUNT, 16'd0, "abort_fifo_empty");
    readReg(ADDR_ECHO_POP, 16'd0, "abort_pop_empty");
    readReg(ADDR_TIMER, 16'd0, "abort_timer");
    checkOutput("abort_echo", 32'(echo), 32'd0);
    checkOutput("abort_irq", 32'(irq), 32'd0);

    // WINDOW=0 acts as a one-sample window; trig_i starts from IDLE
    writeReg(ADDR_WINDOW, 16'd0);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    readReg(ADDR_STATUS, 16'h0001, "w0_trig_armed");
    applyStimulus('0);
    readReg(ADDR_STATUS, 16'h0003, "w0_done");

    // BLANK >= WINDOW: nothing can be detected
    writeReg(ADDR_BLANK, 16'd5);
    writeReg(ADDR_WINDOW, 16'd5);
    writeReg(ADDR_CH_SEL, 16'd0);
    writeReg(ADDR_CONTROL, 16'h0001);
    for (int t = 0; t < 5; t++) applyStimulus(env1(0, 2000));
    readReg(ADDR_STATUS, 16'h0003, "blank_all_done");
    readReg(ADDR_ECHO_COUNT, 16'd0, "blank_all_count");
    checkOutput("blank_all_echo", 32'(echo), 32'd0);

    // Unmapped address, then reset in the middle of a ping
    writeReg(ADDR_BLANK, 16'd0);
    writeReg(ADDR_WINDOW, 16'd100);
    writeReg(4'd12, 16'hFFFF);
    readReg(4'd12, 16'h0000, "unmapped_rd");
    writeReg(ADDR_CONTROL, 16'h0001);
    for (int t = 0; t < 3; t++) applyStimulus(env1(0, 2000));
    checkOutput("mid_echo", 32'(echo), 32'h1);
    readReg(ADDR_ECHO_COUNT, 16'd1, "mid_count");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_echo", 32'(echo), 32'd0);
    checkOutput("async_rst_irq", 32'(irq), 32'd0);
    checkOutput("async_rst_ack", 32'(bus_if.wbs_ack_o), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    readReg(ADDR_STATUS, 16'h0000, "post_rst_status");
    readReg(ADDR_ECHO_COUNT, 16'd0, "post_rst_count");
    readReg(ADDR_WINDOW, 16'd0, "post_rst_window");
    readReg(ADDR_THR_HI_L, 16'd0, "post_rst_thr");
    readReg(ADDR_TIMER, 16'd0, "post_rst_timer");

    repeat (3) tick();
    checkOutput("scoreboard_drained", 32'(exp_val_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
